image_mem_responder: RTL

- Memory-side responder for the pixel-memory access protocol driven by the memory controller.
- Samples an address, a write enable and write data on a request strobe, performs one access per request with a fixed latency (3 cycles by default), and returns read data with an acknowledge.
- Contains the on-chip pixel store and a bulk-clear engine that fills the whole store with a constant, used to blank the output frame before a zoom algorithm runs.

---
 rtl/image_mem_responder_if.sv | 27 ++
 rtl/image_mem_responder.sv | 111 +++++++++++
 2 files changed

// File: rtl/image_mem_responder_if.sv
// Pixel-memory access bus between the memory controller (master) and the
// on-chip pixel store responder (slave).
interface image_mem_responder_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8
);
  logic              req;
  logic              wr_enable;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic              clear_start;
  logic [DATA_W-1:0] clear_value;
  logic [DATA_W-1:0] rd_data;
  logic              ack;
  logic              busy;
  logic              err;

  modport master (
    output req, wr_enable, addr, wr_data, clear_start, clear_value,
    input  rd_data, ack, busy, err
  );

  modport slave (
    input  req, wr_enable, addr, wr_data, clear_start, clear_value,
    output rd_data, ack, busy, err
  );
endinterface

// File: rtl/image_mem_responder.sv
// Pixel store responder: fixed-latency single access per request, plus a
// bulk-clear engine that fills every word with a constant.
//
// state  | meaning
// IDLE   | waiting for req or clear_start
// ACCESS | latency count running; memory op on the last ACCESS edge
// DONE   | ack pulse, busy low, back to IDLE
// CLEAR  | writing clear_value to one word per cycle
module image_mem_responder #(
  parameter int ADDR_W  = 17,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 76800,
  parameter int LATENCY = 3
) (
  input  logic                clock,
  input  logic                reset,
  image_mem_responder_if.slave bus
);

  // Compare against the last valid address so DEPTH == 2**ADDR_W still works.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [2:0]        LAT_LAST  = 3'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, CLEAR} state_t;

  state_t            state;
  logic [2:0]        lat_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] clr_addr;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] clr_val_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              ack_q;
  logic              busy_q;
  logic              err_q;

  logic [DATA_W-1:0] mem [DEPTH];

  // Memory writes sit in the non-reset branch so a reset edge aborts them.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      addr_q    <= '0;
      clr_addr  <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      clr_val_q <= '0;
      rd_data_q <= '0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ack_q <= 1'b0;
          if (bus.req) begin
            addr_q  <= bus.addr;
            we_q    <= bus.wr_enable;
            wdata_q <= bus.wr_data;
            lat_cnt <= 3'd1;
            busy_q  <= 1'b1;
            state   <= ACCESS;
          end else if (bus.clear_start) begin
            clr_val_q <= bus.clear_value;
            clr_addr  <= '0;
            busy_q    <= 1'b1;
            state     <= CLEAR;
          end
        end
        ACCESS: begin
          lat_cnt <= lat_cnt + 3'd1;
          if (lat_cnt == LAT_LAST) begin
            if (addr_q > LAST_ADDR) begin
              err_q <= 1'b1;
              if (!we_q) rd_data_q <= '0;
            end else if (we_q) begin
              mem[addr_q] <= wdata_q;
            end else begin
              rd_data_q <= mem[addr_q];
            end
            ack_q  <= 1'b1;
            busy_q <= 1'b0;
            state  <= DONE;
          end
        end
        DONE: begin
          ack_q <= 1'b0;
          state <= IDLE;
        end
        CLEAR: begin
          mem[clr_addr] <= clr_val_q;
          if (clr_addr == LAST_ADDR) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rd_data = rd_data_q;
  assign bus.ack     = ack_q;
  assign bus.busy    = busy_q;
  assign bus.err     = err_q;

endmodule
